ifetch_queue: RTL and testbench
===============================

Name: ifetch_queue

Overview:
- Instruction fetch stage that sits directly upstream of the instruction memory and downstream-feeds decode.
- Owns the fetch PC, drives the word-aligned fetch address, and captures the combinational read data the same cycle.
- Buffers {pc, instr} pairs in a small FIFO and hands them to decode over a valid/ready handshake.
- Supports a one-cycle redirect (branch / PC write) that flushes all buffered entries.

Parameters:
DEPTH, 4, number of buffered fetch entries; power of two, minimum 2
RESET_PC, 32'h0000_0000, fetch PC loaded on reset

Ports:
clk  input  1  single clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
imem_addr  output  32  fetch byte address to instruction memory; bits [1:0] always 0
imem_rd  input  32  instruction word, combinationally valid for imem_addr in the same cycle
redirect_valid  input  1  load new fetch PC and flush queue this cycle
redirect_pc  input  32  redirect target byte address
out_valid  output  1  head entry present
out_ready  input  1  decode accepts head entry
out_instr  output  32  head instruction word
out_pc  output  32  byte address of head instruction
out_pc_plus8  output  32  out_pc + 8, the architectural R15 read value
count  output  $clog2(DEPTH+1)  number of occupied entries

Behaviour:
- Reset (synchronous, checked before all else): fetch_pc <= RESET_PC; queue empty; count=0; out_valid=0; out_instr=0; out_pc=0; out_pc_plus8=8.
- imem_addr = fetch_pc at all times, combinational from the register; reset/redirect values appear the cycle after the edge.
- pop = out_valid & out_ready.
- push = ~redirect_valid & (count < DEPTH | pop).
  - On push: write {fetch_pc, imem_rd} at the tail.
  - On push: fetch_pc <= fetch_pc + 4, wrapping 32'hFFFF_FFFC -> 0.
- Full with simultaneous pop: push still occurs; count is unchanged.
- Full without pop: no push, fetch_pc holds, imem_addr stable.
- Redirect (redirect_valid=1):
  - Queue cleared next edge; count <= 0.
  - fetch_pc <= {redirect_pc[31:2], 2'b00}; misaligned low bits are silently dropped.
  - No push that cycle.
  - A pop in the same cycle counts as accepted by decode; the head is discarded with the rest.
- Redirect latency: redirect in cycle N -> out_valid=0 in N+1 (target fetched and pushed) -> out_valid=1 with out_pc=target in N+2.
- Steady-state throughput with out_ready=1: one instruction per cycle.
- First valid output after reset is out_valid=1 in the second cycle after reset deasserts.
- Empty queue: out_valid=0; out_instr, out_pc and out_pc_plus8 driven as 0, 0 and 8 (no stale data).
- out_valid, out_instr and out_pc come directly from the head register/slot, with no combinational path from imem_rd.
- Pointers are $clog2(DEPTH) bits and wrap naturally.
- count is tracked separately so that full and empty are unambiguous.
- The queue never stalls on the memory; imem_rd is sampled only when push=1.

Decomposition:
- Package ifetch_pkg:
  - typedef fetch_entry_t struct packed {logic [31:0] pc; logic [31:0] instr;}
  - PC_STEP=4, PC_READ_OFFSET=8, ALIGN_MASK=32'hFFFF_FFFC.
- One sub-module: fetch_fifo, a synchronous FIFO of fetch_entry_t.
  - Parameter DEPTH.
  - Ports: push/pop/flush, head output, count.
- ifetch_queue holds the PC register, push/pop logic and the output mux.

Test Plan:
- Memory model returns 32'hE3A0_0000 | (addr>>2).
  - Stimulus: release reset with out_ready=0.
  - Response: count=1,2,3,4 on successive cycles.
  - Response: imem_addr stops at 0x10.
  - Response: head out_pc=0x0, out_instr=0xE3A00000, out_pc_plus8=0x8.
- Stimulus: hold out_ready=1 from reset.
  - Response: out_valid=1 from the second cycle after reset.
  - Response: out_pc = 0x0, 0x4, 0x8, ... with one instruction per cycle and no bubbles.
- Stimulus: fill to 4, then pulse out_ready=1 for one cycle.
  - Response: count stays 4; the new tail has pc 0x10.
  - Response: the next head has out_pc=0x4.
- Stimulus: redirect_valid=1, redirect_pc=0xE4 while holding 3 entries.
  - Response: count=0 and out_valid=0 next cycle.
  - Response: out_pc=0xE4 with instr 0xE3A00039 one cycle later.
- Stimulus: redirect_pc=0x103.
  - Response: imem_addr=0x100 next cycle; first out_pc=0x100.
- Stimulus: assert reset mid-stream with the queue full and a redirect pending.
  - Response: reset wins; out_valid=0, count=0, imem_addr=RESET_PC next cycle.

Source files
------------

// File: rtl/ifetch_pkg.sv
// ifetch_pkg: fetch entry type and PC arithmetic constants shared by the fetch stage
package ifetch_pkg;
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;
   localparam logic [31:0] PC_STEP = 32'd4;
   localparam logic [31:0] PC_READ_OFFSET = 32'd8;
   localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;
endpackage

// File: rtl/ifetch_queue_fifo.sv
// fetch_fifo: sync FIFO of fetch entries (clk, reset, push, pop, flush, din in; head, count out)
module fetch_fifo
   import ifetch_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       push,
   input  logic                       pop,
   input  logic                       flush,
   input  fetch_entry_t               din,
   output fetch_entry_t               head,
   output logic [$clog2(DEPTH+1)-1:0] count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);
   fetch_entry_t mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   assign head = mem[rd_ptr];
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop) rd_ptr <= rd_ptr + AW'(1);
         count <= count + CW'(push) - CW'(pop);
      end
   end
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= din;
   end
endmodule

// File: rtl/ifetch_queue.sv
// ifetch_queue: owns fetch PC, drives imem_addr, queues {pc,instr} from imem_rd to decode over out_valid/out_ready; redirect flushes
module ifetch_queue
   import ifetch_pkg::*;
#(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic                       clk,
   input  logic                       reset,
   output logic [31:0]                imem_addr,
   input  logic [31:0]                imem_rd,
   input  logic                       redirect_valid,
   input  logic [31:0]                redirect_pc,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [31:0]                out_instr,
   output logic [31:0]                out_pc,
   output logic [31:0]                out_pc_plus8,
   output logic [$clog2(DEPTH+1)-1:0] count
);
   localparam int CW = $clog2(DEPTH+1);
   logic [31:0] fetch_pc;
   logic push, pop;
   fetch_entry_t head;
   assign imem_addr = fetch_pc;
   assign out_valid = count != '0;
   assign pop = out_valid & out_ready;
   assign push = ~redirect_valid & ((count < CW'(DEPTH)) | pop);
   assign out_pc = out_valid ? head.pc : 32'd0;
   assign out_instr = out_valid ? head.instr : 32'd0;
   assign out_pc_plus8 = out_pc + PC_READ_OFFSET;
   always_ff @(posedge clk) begin
      if (reset) fetch_pc <= RESET_PC & ALIGN_MASK;
      else if (redirect_valid) fetch_pc <= redirect_pc & ALIGN_MASK;
      else if (push) fetch_pc <= fetch_pc + PC_STEP;
   end
   fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .flush (redirect_valid),
      .din   ('{pc: fetch_pc, instr: imem_rd}),
      .head  (head),
      .count (count)
   );
endmodule

// File: tb/tb_ifetch_queue.sv
// tb_ifetch_queue: directed table-driven bench for ifetch_queue with a combinational memory model
module tb_ifetch_queue;
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic [31:0] imem_addr, imem_rd;
   logic redirect_valid = 1'b0;
   logic [31:0] redirect_pc = 32'd0;
   logic out_valid;
   logic out_ready = 1'b0;
   logic [31:0] out_instr, out_pc, out_pc_plus8;
   logic [2:0] count;
   int checks = 0;
   int failures = 0;
   always #5 clk = ~clk;
   assign imem_rd = 32'hE3A0_0000 | (imem_addr >> 2);
   ifetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) dut (
      .clk            (clk),
      .reset          (reset),
      .imem_addr      (imem_addr),
      .imem_rd        (imem_rd),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_instr      (out_instr),
      .out_pc         (out_pc),
      .out_pc_plus8   (out_pc_plus8),
      .count          (count)
   );
   typedef struct {
      logic        rst;
      logic        rv;
      logic [31:0] rpc;
      logic        rdy;
      logic        valid;
      logic [2:0]  cnt;
      logic [31:0] addr;
      logic [31:0] pc;
      logic [31:0] instr;
   } vec_t;
   vec_t vecs [30];
   function automatic vec_t mk(logic rst, logic rv, logic [31:0] rpc, logic rdy, logic valid,
                               logic [2:0] cnt, logic [31:0] addr, logic [31:0] pc, logic [31:0] instr);
      vec_t v;
      v.rst = rst; v.rv = rv; v.rpc = rpc; v.rdy = rdy; v.valid = valid;
      v.cnt = cnt; v.addr = addr; v.pc = pc; v.instr = instr;
      return v;
   endfunction
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   initial begin
      int n;
      vecs[0]  = mk(1, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0);
      vecs[1]  = mk(0, 0, 0, 0, 1, 1, 32'h4,        32'h0,        32'hE3A00000);
      vecs[2]  = mk(0, 0, 0, 0, 1, 2, 32'h8,        32'h0,        32'hE3A00000);
      vecs[3]  = mk(0, 0, 0, 0, 1, 3, 32'hC,        32'h0,        32'hE3A00000);
      vecs[4]  = mk(0, 0, 0, 0, 1, 4, 32'h10,       32'h0,        32'hE3A00000);
      vecs[5]  = mk(0, 0, 0, 0, 1, 4, 32'h10,       32'h0,        32'hE3A00000);
      vecs[6]  = mk(0, 0, 0, 1, 1, 4, 32'h14,       32'h4,        32'hE3A00001);
      vecs[7]  = mk(0, 0, 0, 0, 1, 4, 32'h14,       32'h4,        32'hE3A00001);
      vecs[8]  = mk(1, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0);
      vecs[9]  = mk(0, 0, 0, 0, 1, 1, 32'h4,        32'h0,        32'hE3A00000);
      vecs[10] = mk(0, 0, 0, 0, 1, 2, 32'h8,        32'h0,        32'hE3A00000);
      vecs[11] = mk(0, 0, 0, 0, 1, 3, 32'hC,        32'h0,        32'hE3A00000);
      vecs[12] = mk(0, 1, 32'hE4, 0, 0, 0, 32'hE4,  32'h0,        32'h0);
      vecs[13] = mk(0, 0, 0, 0, 1, 1, 32'hE8,       32'hE4,       32'hE3A00039);
      vecs[14] = mk(0, 0, 0, 1, 1, 1, 32'hEC,       32'hE8,       32'hE3A0003A);
      vecs[15] = mk(0, 0, 0, 1, 1, 1, 32'hF0,       32'hEC,       32'hE3A0003B);
      vecs[16] = mk(0, 1, 32'h103, 1, 0, 0, 32'h100, 32'h0,       32'h0);
      vecs[17] = mk(0, 0, 0, 1, 1, 1, 32'h104,      32'h100,      32'hE3A00040);
      vecs[18] = mk(0, 0, 0, 1, 1, 1, 32'h108,      32'h104,      32'hE3A00041);
      vecs[19] = mk(0, 0, 0, 0, 1, 2, 32'h10C,      32'h104,      32'hE3A00041);
      vecs[20] = mk(0, 0, 0, 0, 1, 3, 32'h110,      32'h104,      32'hE3A00041);
      vecs[21] = mk(0, 0, 0, 0, 1, 4, 32'h114,      32'h104,      32'hE3A00041);
      vecs[22] = mk(0, 0, 0, 0, 1, 4, 32'h114,      32'h104,      32'hE3A00041);
      vecs[23] = mk(1, 1, 32'h200, 1, 0, 0, 32'h0,  32'h0,        32'h0);
      vecs[24] = mk(0, 0, 0, 1, 1, 1, 32'h4,        32'h0,        32'hE3A00000);
      vecs[25] = mk(0, 0, 0, 1, 1, 1, 32'h8,        32'h4,        32'hE3A00001);
      vecs[26] = mk(0, 0, 0, 1, 1, 1, 32'hC,        32'h8,        32'hE3A00002);
      vecs[27] = mk(0, 1, 32'hFFFFFFFF, 1, 0, 0, 32'hFFFFFFFC, 32'h0, 32'h0);
      vecs[28] = mk(0, 0, 0, 0, 1, 1, 32'h0,        32'hFFFFFFFC, 32'hFFFFFFFF);
      vecs[29] = mk(0, 0, 0, 0, 1, 2, 32'h4,        32'hFFFFFFFC, 32'hFFFFFFFF);
      for (int i = 0; i < 30; i++) begin
         reset = vecs[i].rst;
         redirect_valid = vecs[i].rv;
         redirect_pc = vecs[i].rpc;
         out_ready = vecs[i].rdy;
         tick();
         check($sformatf("v%0d out_valid", i), {31'd0, out_valid}, {31'd0, vecs[i].valid});
         check($sformatf("v%0d count", i), {29'd0, count}, {29'd0, vecs[i].cnt});
         check($sformatf("v%0d imem_addr", i), imem_addr, vecs[i].addr);
         check($sformatf("v%0d out_pc", i), out_pc, vecs[i].pc);
         check($sformatf("v%0d out_instr", i), out_instr, vecs[i].instr);
         check($sformatf("v%0d out_pc_plus8", i), out_pc_plus8, vecs[i].pc + 32'd8);
      end
      redirect_valid = 1'b1;
      redirect_pc = 32'h40;
      out_ready = 1'b1;
      tick();
      redirect_valid = 1'b0;
      n = 0;
      while (!out_valid && n < 5) begin
         tick();
         n++;
      end
      check("redirect_latency", n, 1);
      for (int k = 0; k < 6; k++) begin
         check($sformatf("stream%0d out_valid", k), {31'd0, out_valid}, 32'd1);
         check($sformatf("stream%0d out_pc", k), out_pc, 32'h40 + 32'(4 * k));
         check($sformatf("stream%0d out_instr", k), out_instr, 32'hE3A00010 + 32'(k));
         tick();
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
